// File: rtl/their_seq_process.sv
// Receive-side SEQ check: classifies each incoming segment against rcv_nxt and produces the next receive state.
// Define THEIR_SEQ_DELAYED_ACK_EN to ACK every ACK_EVERY_N in-order segments; otherwise every accepted segment is ACKed.
module their_seq_process #(
    parameter int FLOWID_W         = 8,
    parameter int ACK_EVERY_N      = 2,
    parameter int RX_PAYLOAD_PTR_W = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        seg_val,
    output logic                        seg_rdy,
    input  logic [FLOWID_W-1:0]         seg_flowid,
    input  logic [31:0]                 seg_seq_num,
    input  logic [15:0]                 seg_payload_len,
    input  logic                        seg_fin,
    input  logic [31:0]                 curr_rx_ack_num,
    input  logic [3:0]                  curr_segs_unacked,
    input  logic [RX_PAYLOAD_PTR_W:0]   rx_free_space,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [FLOWID_W-1:0]         out_flowid,
    output logic [31:0]                 next_rx_ack_num,
    output logic [3:0]                  next_segs_unacked,
    output logic                        accept_payload,
    output logic                        send_ack_now,
    output logic                        seg_dup,
    output logic                        seg_ooo,
    output logic [RX_PAYLOAD_PTR_W:0]   next_rx_tail_ptr
);

`ifdef THEIR_SEQ_DELAYED_ACK_EN
    localparam bit DELAYED_ACK = 1'b1;
`else
    localparam bit DELAYED_ACK = 1'b0;
`endif
    localparam int         FREE_W     = RX_PAYLOAD_PTR_W + 1;
    localparam int         CMP_W      = ((FREE_W > 16) ? FREE_W : 16) + 1;
    // A threshold of 1 makes every accepted segment force an ACK and keeps the count at zero.
    localparam logic [4:0] ACK_THRESH = DELAYED_ACK ? 5'(ACK_EVERY_N) : 5'd1;

    logic                s1_val;
    logic [FLOWID_W-1:0] s1_flowid;
    logic [31:0]         s1_seq;
    logic [15:0]         s1_len;
    logic                s1_fin;
    logic [FREE_W-1:0]   s1_free;
    logic [31:0]         s1_base_ack;
    logic [3:0]          s1_base_cnt;

    logic                commit_val;
    logic [FLOWID_W-1:0] commit_flowid;
    logic [31:0]         commit_ack;
    logic [3:0]          commit_cnt;

    logic                s1_advance;
    logic [31:0]         base_ack;
    logic [3:0]          base_cnt;
    logic [31:0]         diff;
    logic [4:0]          cnt_inc;
    logic [CMP_W-1:0]    len_ext;
    logic [CMP_W-1:0]    free_ext;

    logic [31:0]         res_ack;
    logic [3:0]          res_cnt;
    logic                res_acc;
    logic                res_send;
    logic                res_dup;
    logic                res_ooo;

    assign s1_advance       = ~out_val | out_rdy;
    assign seg_rdy          = ~s1_val | s1_advance;
    assign next_rx_tail_ptr = next_rx_ack_num[RX_PAYLOAD_PTR_W:0];

    assign diff     = s1_seq - base_ack;
    assign cnt_inc  = {1'b0, base_cnt} + 5'd1;
    assign len_ext  = CMP_W'(s1_len);
    assign free_ext = CMP_W'(s1_free);

    // The newest same-flow result wins: stage 2, then the just-committed entry, then the memory read.
    always_comb begin
        base_ack = s1_base_ack;
        base_cnt = s1_base_cnt;
        if (out_val && (out_flowid == s1_flowid)) begin
            base_ack = next_rx_ack_num;
            base_cnt = next_segs_unacked;
        end else if (commit_val && (commit_flowid == s1_flowid)) begin
            base_ack = commit_ack;
            base_cnt = commit_cnt;
        end
    end

    always_comb begin
        res_ack  = base_ack;
        res_cnt  = 4'd0;
        res_acc  = 1'b0;
        res_send = 1'b1;
        res_dup  = diff[31];
        res_ooo  = ~diff[31] & (diff != 32'd0);
        if (diff == 32'd0) begin
            if (s1_len == 16'd0) begin
                if (s1_fin) begin
                    res_ack = base_ack + 32'd1;
                end else begin
                    res_send = 1'b0;
                    res_cnt  = base_cnt;
                end
            end else if (len_ext <= free_ext) begin
                res_acc = 1'b1;
                res_ack = base_ack + {16'd0, s1_len} + {31'd0, s1_fin};
                if ((cnt_inc < ACK_THRESH) && !s1_fin) begin
                    res_send = 1'b0;
                    res_cnt  = cnt_inc[3:0];
                end
            end
        end
    end

    // While stalled, stage 1 re-latches the forwarded base so it survives the commit entry expiring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val      <= 1'b0;
            s1_flowid   <= '0;
            s1_seq      <= '0;
            s1_len      <= '0;
            s1_fin      <= 1'b0;
            s1_free     <= '0;
            s1_base_ack <= '0;
            s1_base_cnt <= '0;
        end else if (seg_rdy) begin
            s1_val <= seg_val;
            if (seg_val) begin
                s1_flowid   <= seg_flowid;
                s1_seq      <= seg_seq_num;
                s1_len      <= seg_payload_len;
                s1_fin      <= seg_fin;
                s1_free     <= rx_free_space;
                s1_base_ack <= curr_rx_ack_num;
                s1_base_cnt <= DELAYED_ACK ? curr_segs_unacked : 4'd0;
            end
        end else if (s1_val) begin
            s1_base_ack <= base_ack;
            s1_base_cnt <= base_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val           <= 1'b0;
            out_flowid        <= '0;
            next_rx_ack_num   <= '0;
            next_segs_unacked <= '0;
            accept_payload    <= 1'b0;
            send_ack_now      <= 1'b0;
            seg_dup           <= 1'b0;
            seg_ooo           <= 1'b0;
        end else if (s1_advance) begin
            out_val <= s1_val;
            if (s1_val) begin
                out_flowid        <= s1_flowid;
                next_rx_ack_num   <= res_ack;
                next_segs_unacked <= res_cnt;
                accept_payload    <= res_acc;
                send_ack_now      <= res_send;
                seg_dup           <= res_dup;
                seg_ooo           <= res_ooo;
            end
        end
    end

    // Covers the one cycle in which the flow-state memory has not yet absorbed the write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_val    <= 1'b0;
            commit_flowid <= '0;
            commit_ack    <= '0;
            commit_cnt    <= '0;
        end else begin
            commit_val <= out_val & out_rdy;
            if (out_val && out_rdy) begin
                commit_flowid <= out_flowid;
                commit_ack    <= next_rx_ack_num;
                commit_cnt    <= next_segs_unacked;
            end
        end
    end

endmodule

// File: doc/their_seq_process.md
Name: their_seq_process

Overview:
- Receive-side counterpart of our ACK processing.
- Consumes per-segment info for incoming data (their SEQ number, payload length, FIN) together with the flow's current receive state read from flow-state memory.
- Decides whether the payload is accepted, computes the next receive state (our ACK number for their data plus the delayed-ACK count), and flags when an ACK must be sent immediately.
- Sits between the RX header parser and the RX flow-state memory / TX ACK request queue. It is a 2-stage valid/ready pipeline with same-flow state forwarding.

Parameters:
- FLOWID_W, 8, flow ID width.
- ACK_EVERY_N, 2, accepted in-order segments per forced ACK (range 1..15).
- RX_PAYLOAD_PTR_W, 14, RX buffer pointer width. The buffer is 2^RX_PAYLOAD_PTR_W bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- seg_val  in  1  segment request valid
- seg_rdy  out  1  segment request ready
- seg_flowid  in  FLOWID_W  flow of segment
- seg_seq_num  in  32  segment SEQ number
- seg_payload_len  in  16  payload bytes
- seg_fin  in  1  FIN flag
- curr_rx_ack_num  in  32  stored next-expected SEQ (rcv_nxt)
- curr_segs_unacked  in  4  stored delayed-ACK count
- rx_free_space  in  RX_PAYLOAD_PTR_W+1  free RX buffer bytes
- out_val  out  1  result valid
- out_rdy  in  1  result ready
- out_flowid  out  FLOWID_W  flow of result
- next_rx_ack_num  out  32  rcv_nxt to write back
- next_segs_unacked  out  4  count to write back
- accept_payload  out  1  copy payload into RX buffer
- send_ack_now  out  1  enqueue an immediate ACK
- seg_dup  out  1  segment entirely old
- seg_ooo  out  1  segment ahead of rcv_nxt
- next_rx_tail_ptr  out  RX_PAYLOAD_PTR_W+1  equals next_rx_ack_num[RX_PAYLOAD_PTR_W:0]

Behaviour:
- Reset: all stage valids = 0, out_val = 0, all other outputs = 0, committed-bypass entry invalid. Reset mid-operation drops in-flight requests with no output.
- Handshake:
  - Transfer occurs when val & rdy; seg_rdy = ~s1_val | s1_advance.
  - Stage 1 advances when ~s2_val | out_rdy. Outputs are registered in stage 2 and held stable while out_val & ~out_rdy.
  - Latency is 2 cycles from the seg handshake to out_val with no backpressure. Throughput is 1 per cycle.
- Forwarding, stage 1 chooses the base state in priority order:
  - (a) stage-2 result if s2_val and flowid equal;
  - (b) committed entry (last handshaken output) if valid and flowid equal, held 1 cycle after commit;
  - (c) curr_* ports.
- Classification uses diff = seg_seq_num - rcv_nxt mod 2^32, read as signed:
  - diff == 0: in order.
  - diff < 0: seg_dup = 1.
  - diff > 0: seg_ooo = 1.
  - Wrap-around at 2^32 needs no special case.
- In order, len > 0, len <= rx_free_space:
  - accept_payload = 1.
  - next_rx_ack_num = rcv_nxt + len + seg_fin (mod 2^32).
  - cnt = segs_unacked + 1. If cnt >= ACK_EVERY_N or seg_fin, then send_ack_now = 1 and next_segs_unacked = 0; else next_segs_unacked = cnt.
- In order, len > rx_free_space: accept_payload = 0, state unchanged, send_ack_now = 1, count = 0.
- In order, len == 0:
  - Without FIN: no state change, send_ack_now = 0.
  - With FIN: rcv_nxt + 1, send_ack_now = 1, count = 0.
- Dup or OOO: accept_payload = 0, rcv_nxt unchanged, send_ack_now = 1, next_segs_unacked = 0.

Optional Feature:
- Macro THEIR_SEQ_DELAYED_ACK_EN.
- Defined: delayed-ACK counting as above.
- Undefined: every accepted in-order segment sets send_ack_now = 1, and next_segs_unacked is always 0. curr_segs_unacked is ignored.

Test Plan:
- rcv_nxt = 1000, cnt = 0; seg seq = 1000, len = 100, free = 4096 -> accept = 1, next = 1100, cnt = 1, send_ack_now = 0 (2 cycles later).
- Same flow back-to-back, seqs 1000 then 1100, len 100 each, curr_* stale at 1000 -> second result: next = 1200, send_ack_now = 1, cnt = 0, via forwarding.
- rcv_nxt = 32'hFFFF_FFF0, seq = 32'hFFFF_FFF0, len = 32 -> accept, next = 32'h0000_0010. Then seq = 32'hFFFF_FFE0 -> seg_dup = 1, send_ack_now = 1.
- rcv_nxt = 5000, seq = 5200 -> seg_ooo = 1, accept = 0, next = 5000, send_ack_now = 1. Len 200 with free = 100 at seq 5000 -> accept = 0, send_ack_now = 1.
- out_rdy held low 5 cycles with 3 segments offered -> seg_rdy = 0 once both stages are full, outputs stable, no loss or reorder. Assert rst_n low mid-stream -> out_val = 0 immediately.
- FIN, len = 0, seq = rcv_nxt = 700 -> next = 701, send_ack_now = 1. With the macro undefined, the first test gives send_ack_now = 1, cnt = 0.
